vga_tile_renderer: RTL and testbench
====================================

Name: vga_tile_renderer

Overview:
- Pixel source that sits directly upstream of the VGA controller. It drives the controller's iRGB input from the row/column coordinates the controller produces.
- Holds a 40x30 tile map of 3-bit colours; each tile is 16x16 pixels, covering 640x480.
- A host-side write port with a valid/ready handshake updates the map, and a hardware clear engine fills the whole map with one colour.

Parameters:
- TILES_X, 40, tiles per row
- TILES_Y, 30, tiles per column
- TILE_SHIFT, 4, log2 of tile edge in pixels (16)
- BLINK_SHIFT, 5, cursor toggles every 2^BLINK_SHIFT frames

Ports:
- Clock  input  1  same clock as the controller's clock_ref (50 MHz)
- Reset  input  1  synchronous, active-high
- row  input  9  from controller; 0 = blanking, 1..479 active
- column  input  10  from controller; 0 = blanking, 1..639 active
- v_sync  input  1  from controller; active-low frame pulse
- wr_valid  input  1  host write request
- wr_ready  output  1  host write can be accepted this cycle
- wr_x  input  6  tile column
- wr_y  input  5  tile row
- wr_color  input  3  tile colour
- wr_err  output  1  one-cycle pulse when an accepted write is out of range
- clear_req  input  1  start a fill of the whole map
- clear_color  input  3  fill colour, sampled on clear start
- clear_busy  output  1  fill in progress
- cursor_x  input  6  cursor tile column
- cursor_y  input  5  cursor tile row
- pixel_rgb  output  3  colour to the controller's iRGB

Behaviour:
- Reset: all of the following apply, and Reset mid-clear aborts the clear immediately.
  - State goes to IDLE; clear_busy=0, wr_err=0, pixel_rgb=3'b000, blink counter=0, cursor phase=0.
  - Tile map contents are not reset; its contents after Reset are undefined until a clear runs.
- Memory: 1200 x 3 bits, one write port and one read port (dual-port).
  - Address = y*TILES_X + x, computed as (y<<5)+(y<<3)+x, 11 bits.
  - Reads are never stalled by writes or clears.
- Read pipeline, 2-cycle latency from row/column to pixel_rgb:
  - Cycle 0: register row/column and an active flag. active = (row!=0 && column!=0).
  - Address computed from tx=(column-1)>>TILE_SHIFT and ty=(row-1)>>TILE_SHIFT.
  - Cycle 1: memory read is registered.
  - Cycle 2: pixel_rgb = active_d2 ? tile colour (after the cursor rule) : 3'b000.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clear_req=1. On that cycle clear_color is latched and the address counter is set to 0.
  - CLEAR writes the latched colour to one address per cycle, from 0 to 1199.
  - CLEAR -> IDLE on the cycle after address 1199 is written. A full fill takes exactly 1200 cycles with clear_busy=1.
  - clear_req while in CLEAR is ignored (not queued).
- Write handshake:
  - wr_ready = (state==IDLE) && !clear_req, combinational.
  - A transfer happens when wr_valid && wr_ready, and commits on that Clock edge.
  - Simultaneous clear_req and wr_valid in IDLE: the clear wins and the write is not accepted. The host must hold wr_valid.
  - Out of range (wr_x>=TILES_X or wr_y>=TILES_Y): the transfer completes, no memory write occurs, and wr_err pulses high for 1 cycle after the accept edge.
- Frame counter:
  - A falling edge of v_sync (v_sync registered, previous=1 and current=0) increments the BLINK_SHIFT-bit counter.
  - On wrap to 0, the cursor phase toggles.
- Boundaries: column 640 and above, or row 480 and above, are treated as inactive (black). This cannot occur from the controller but is guarded.

Optional Feature:
- Macro: VGA_TILE_CURSOR_EN.
- Defined: during cycle 2 of the read pipeline, if the pixel's tile equals (cursor_x, cursor_y) and cursor phase=1, pixel_rgb = ~tile colour.
- Not defined: the cursor ports remain present but are ignored; the frame counter and phase logic are not generated; pixel_rgb is always the plain tile colour.

Test Plan:
- Reset, then assert clear_req with clear_color=3'b001 -> clear_busy high for exactly 1200 cycles, wr_ready=0 throughout; afterwards any active row/column gives pixel_rgb=3'b001 two cycles later.
- Write (x=2, y=1, color=3'b110), then drive row=17, column=33 -> pixel_rgb=3'b110 after 2 cycles; row=16, column=33 gives the clear colour; row=0 or column=0 gives 3'b000.
- Write with wr_x=40 or wr_y=30 -> wr_ready=1, transfer accepted, wr_err pulses 1 cycle, tile map unchanged (verified by readback of tile (0,0)).
- clear_req and wr_valid in the same IDLE cycle -> write not accepted and clear starts; the held write is accepted on the first cycle after clear_busy falls.
- Reset asserted at cycle 600 of a clear -> next cycle state=IDLE, clear_busy=0, wr_ready=1, pixel_rgb=3'b000.
- With VGA_TILE_CURSOR_EN defined: cursor=(3,3) over colour 3'b010, 32 v_sync falling edges -> pixel at row=49, column=49 reads 3'b101; after 32 more edges it reads 3'b010.

Source files
------------

// File: rtl/vga_tile_renderer.sv
// Tile-map pixel source for the VGA controller: 40x30 map of 3-bit colours, host write port and fill engine.
// Optional blinking cursor overlay enabled by defining VGA_TILE_CURSOR_EN.
module vga_tile_renderer #(
    parameter int unsigned TILES_X     = 40,
    parameter int unsigned TILES_Y     = 30,
    parameter int unsigned TILE_SHIFT  = 4,
    parameter int unsigned BLINK_SHIFT = 5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [8:0] i_row,
    input  logic [9:0] i_column,
    input  logic       i_v_sync,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    input  logic [5:0] i_wr_x,
    input  logic [4:0] i_wr_y,
    input  logic [2:0] i_wr_color,
    output logic       o_wr_err,
    input  logic       i_clear_req,
    input  logic [2:0] i_clear_color,
    output logic       o_clear_busy,
    input  logic [5:0] i_cursor_x,
    input  logic [4:0] i_cursor_y,
    output logic [2:0] o_pixel_rgb
);
    localparam int unsigned AW        = 11;
    localparam int unsigned MEM_DEPTH = TILES_X * TILES_Y;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
    localparam logic [8:0] ROW_LIMIT = 9'(TILES_Y << TILE_SHIFT);
    localparam logic [9:0] COL_LIMIT = 10'(TILES_X << TILE_SHIFT);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_clr_start;
    logic [AW-1:0]   r_clr_addr;
    logic [2:0]      r_clr_color;
    logic [2:0]      r_mem [0:MEM_DEPTH-1];
    logic [2:0]      r_rd_data;
    logic            r_active_d1;
    logic [2:0]      r_pixel;
    logic            r_wr_err;

    logic            w_wr_accept;
    logic            w_wr_oor;
    logic [AW-1:0]   w_wr_addr;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_waddr;
    logic [2:0]      w_mem_wdata;

    logic [9:0]      w_col_m1;
    logic [8:0]      w_row_m1;
    logic [5:0]      w_tx;
    logic [4:0]      w_ty;
    logic            w_active;
    logic [AW-1:0]   w_rd_addr;

    assign o_wr_ready   = (r_state == IDLE) && !i_clear_req;
    assign o_clear_busy = (r_state == CLEAR);
    assign o_wr_err     = r_wr_err;
    assign o_pixel_rgb  = r_pixel;

    assign w_wr_accept = i_wr_valid && o_wr_ready && !i_rst;
    assign w_wr_oor    = (i_wr_x >= 6'(TILES_X)) || (i_wr_y >= 5'(TILES_Y));
    assign w_wr_addr   = (AW'(i_wr_y) << 5) + (AW'(i_wr_y) << 3) + AW'(i_wr_x);

    // Next-state and clear-start decode
    always_comb begin
        w_next_state = r_state;
        w_clr_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_clear_req) begin
                    w_next_state = CLEAR;
                    w_clr_start  = 1'b1;
                end
            end
            CLEAR: begin
                if (r_clr_addr == LAST_ADDR) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_clr_addr  <= '0;
            r_clr_color <= 3'b000;
            r_wr_err    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_wr_err <= w_wr_accept && w_wr_oor;
            if (w_clr_start) begin
                r_clr_addr  <= '0;
                r_clr_color <= i_clear_color;
            end else if (r_state == CLEAR) begin
                r_clr_addr <= r_clr_addr + AW'(1);
            end
        end
    end

    // Single write port shared by the fill engine and host writes
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = r_clr_addr;
        w_mem_wdata = r_clr_color;
        if (r_state == CLEAR) begin
            w_mem_we = !i_rst;
        end else if (w_wr_accept && !w_wr_oor) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = w_wr_addr;
            w_mem_wdata = i_wr_color;
        end
    end

    assign w_col_m1  = i_column - 10'd1;
    assign w_row_m1  = i_row - 9'd1;
    assign w_tx      = 6'(w_col_m1 >> TILE_SHIFT);
    assign w_ty      = 5'(w_row_m1 >> TILE_SHIFT);
    assign w_active  = (i_row != 9'd0) && (i_column != 10'd0) &&
                       (i_row < ROW_LIMIT) && (i_column < COL_LIMIT);
    // Inactive coordinates may map past the map; park the read on address 0
    assign w_rd_addr = w_active ? ((AW'(w_ty) << 5) + (AW'(w_ty) << 3) + AW'(w_tx)) : '0;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
        r_rd_data <= r_mem[w_rd_addr];
    end

`ifdef VGA_TILE_CURSOR_EN
    logic                   r_vs_d1;
    logic                   r_vs_d2;
    logic [BLINK_SHIFT-1:0] r_blink_cnt;
    logic                   r_phase;
    logic                   r_hit_d1;
    logic                   w_vs_fall;

    assign w_vs_fall = r_vs_d2 && !r_vs_d1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vs_d1     <= 1'b1;
            r_vs_d2     <= 1'b1;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_hit_d1    <= 1'b0;
            r_active_d1 <= 1'b0;
            r_pixel     <= 3'b000;
        end else begin
            r_vs_d1     <= i_v_sync;
            r_vs_d2     <= r_vs_d1;
            if (w_vs_fall) begin
                r_blink_cnt <= r_blink_cnt + BLINK_SHIFT'(1);
                if (&r_blink_cnt) r_phase <= !r_phase;
            end
            r_hit_d1    <= (w_tx == i_cursor_x) && (w_ty == i_cursor_y);
            r_active_d1 <= w_active;
            if (!r_active_d1)                r_pixel <= 3'b000;
            else if (r_hit_d1 && r_phase)    r_pixel <= ~r_rd_data;
            else                             r_pixel <= r_rd_data;
        end
    end
`else
    logic w_unused_ok;
    assign w_unused_ok = ^{i_cursor_x, i_cursor_y, i_v_sync};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active_d1 <= 1'b0;
            r_pixel     <= 3'b000;
        end else begin
            r_active_d1 <= w_active;
            r_pixel     <= r_active_d1 ? r_rd_data : 3'b000;
        end
    end
`endif

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed self-checking bench for vga_tile_renderer; cursor steps adapt to VGA_TILE_CURSOR_EN.
module tb_vga_tile_renderer;
    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] row;
    logic [9:0] column;
    logic       v_sync;
    logic       wr_valid;
    logic       wr_ready;
    logic [5:0] wr_x;
    logic [4:0] wr_y;
    logic [2:0] wr_color;
    logic       wr_err;
    logic       clear_req;
    logic [2:0] clear_color;
    logic       clear_busy;
    logic [5:0] cursor_x;
    logic [4:0] cursor_y;
    logic [2:0] pixel_rgb;

    int checks   = 0;
    int failures = 0;
    int cycles;
    bit rdy_low;

    always #10 clk = ~clk;

    vga_tile_renderer dut (
        .i_clk(clk), .i_rst(rst), .i_row(row), .i_column(column), .i_v_sync(v_sync),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_x(wr_x), .i_wr_y(wr_y),
        .i_wr_color(wr_color), .o_wr_err(wr_err), .i_clear_req(clear_req),
        .i_clear_color(clear_color), .o_clear_busy(clear_busy),
        .i_cursor_x(cursor_x), .i_cursor_y(cursor_y), .o_pixel_rgb(pixel_rgb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic pix(input string tag, input int r, input int c, input int expected);
        row    = 9'(r);
        column = 10'(c);
        tick();
        tick();
        chk(tag, int'(pixel_rgb), expected);
    endtask

    // Counts busy cycles and notes whether wr_ready ever rose during the fill
    task automatic wait_clear(output int n, output bit ready_low);
        n = 0;
        ready_low = 1'b1;
        while (clear_busy === 1'b1 && n < 1300) begin
            if (wr_ready !== 1'b0) ready_low = 1'b0;
            n++;
            tick();
        end
    endtask

    task automatic vs_fall();
        v_sync = 1'b0;
        tick();
        tick();
        v_sync = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; row = '0; column = '0; v_sync = 1'b1;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
        clear_req = 1'b0; clear_color = '0; cursor_x = '0; cursor_y = '0;
        repeat (3) tick();
        chk("rst_busy", int'(clear_busy), 0);
        chk("rst_wr_err", int'(wr_err), 0);
        chk("rst_pixel", int'(pixel_rgb), 0);
        chk("rst_ready", int'(wr_ready), 1);
        rst = 1'b0;
        tick();

        // Full fill with colour 1
        clear_req = 1'b1; clear_color = 3'b001;
        #1;
        chk("ready_during_req", int'(wr_ready), 0);
        tick();
        clear_req = 1'b0;
        wait_clear(cycles, rdy_low);
        chk("clear_cycles", cycles, 1200);
        chk("clear_ready_low", int'(rdy_low), 1);
        chk("post_clear_ready", int'(wr_ready), 1);
        pix("fill_mid", 100, 200, 1);
        pix("fill_last_tile", 479, 639, 1);
        pix("row_480_black", 480, 5, 0);
        pix("col_640_black", 5, 640, 0);

        // Host write of tile (2,1)
        wr_valid = 1'b1; wr_x = 6'd2; wr_y = 5'd1; wr_color = 3'b110;
        #1;
        chk("wr_ready", int'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
        chk("wr_err_inrange", int'(wr_err), 0);
        pix("tile_2_1", 17, 33, 6);
        pix("tile_2_0", 16, 33, 1);
        pix("row0_black", 0, 33, 0);
        pix("col0_black", 17, 0, 0);

        // Out-of-range writes: accepted, flagged, no memory change
        wr_valid = 1'b1; wr_x = 6'd40; wr_y = 5'd0; wr_color = 3'b111;
        #1;
        chk("oor_x_ready", int'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
        chk("oor_x_err", int'(wr_err), 1);
        tick();
        chk("oor_x_err_drop", int'(wr_err), 0);
        wr_valid = 1'b1; wr_x = 6'd0; wr_y = 5'd30;
        #1;
        chk("oor_y_ready", int'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
        chk("oor_y_err", int'(wr_err), 1);
        tick();
        chk("oor_y_err_drop", int'(wr_err), 0);
        pix("oor_tile_0_0", 1, 1, 1);
        pix("oor_tile_0_1", 17, 1, 1);

        // Clear and write collide: clear wins, write held until fill ends
        wr_valid = 1'b1; wr_x = 6'd5; wr_y = 5'd5; wr_color = 3'b011;
        clear_req = 1'b1; clear_color = 3'b100;
        #1;
        chk("collide_ready", int'(wr_ready), 0);
        tick();
        clear_req = 1'b0;
        chk("collide_busy", int'(clear_busy), 1);
        wait_clear(cycles, rdy_low);
        chk("collide_cycles", cycles, 1200);
        chk("collide_ready_low", int'(rdy_low), 1);
        chk("held_write_ready", int'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
        pix("held_write_tile", 81, 81, 3);
        pix("collide_fill", 1, 1, 4);

        // Reset at cycle 600 of a fill
        clear_req = 1'b1; clear_color = 3'b010;
        tick();
        clear_req = 1'b0;
        repeat (599) tick();
        chk("mid_clear_busy", int'(clear_busy), 1);
        rst = 1'b1;
        tick();
        chk("abort_busy", int'(clear_busy), 0);
        chk("abort_ready", int'(wr_ready), 1);
        chk("abort_pixel", int'(pixel_rgb), 0);
        rst = 1'b0;
        pix("abort_tile_0_0", 1, 1, 2);

        // Cursor tile (3,3) over colour 2, blink after 32 frames
        wr_valid = 1'b1; wr_x = 6'd3; wr_y = 5'd3; wr_color = 3'b010;
        tick();
        wr_valid = 1'b0;
        cursor_x = 6'd3; cursor_y = 5'd3;
        pix("cursor_phase0", 49, 49, 2);
        repeat (32) vs_fall();
`ifdef VGA_TILE_CURSOR_EN
        chk("cursor_phase1", int'(pixel_rgb), 5);
        pix("cursor_other_tile", 33, 49, 2);
        row = 9'd49; column = 10'd49;
`else
        chk("cursor_ignored", int'(pixel_rgb), 2);
`endif
        repeat (32) vs_fall();
        chk("cursor_phase_back", int'(pixel_rgb), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
